// File: rtl/smmha_engine.sv
// smmha datapath engine: applies "word OP operand" to len words through a 2-stage stallable pipeline.
// Optional macro SMMHA_SATURATE_EN: signed saturating ADD/SUB/MUL instead of modulo-2^DATA_W wrap.
module smmha_engine #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  len_i,
  input  logic [DATA_W-1:0] operand_i,
  input  logic [1:0]        operation_i,
  input  logic              a_valid_i,
  output logic              a_ready_o,
  input  logic [DATA_W-1:0] a_data_i,
  output logic              d_valid_o,
  input  logic              d_ready_i,
  output logic [DATA_W-1:0] d_data_o,
  output logic [CNT_W-1:0]  cnt_o,
  output logic              busy_o,
  output logic              done_o
);
  typedef enum logic {IDLE, RUN} state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  len_q, in_cnt_q, cnt_q;
  logic [DATA_W-1:0] operand_q, s1_data_q, s2_data_q, alu_d;
  logic [1:0]        op_q;
  logic              s1_valid_q, s2_valid_q, done_q;
  logic              run, adv, a_hs, d_hs, last_beat;

  assign run       = (state_q == RUN);
  assign adv       = !s2_valid_q || d_ready_i;
  assign a_ready_o = run && (in_cnt_q < len_q) && adv;
  assign a_hs      = a_valid_i && a_ready_o;
  assign d_hs      = s2_valid_q && d_ready_i;
  assign last_beat = d_hs && ((cnt_q + CNT_W'(1)) == len_q);

  assign d_valid_o = s2_valid_q;
  assign d_data_o  = s2_data_q;
  assign cnt_o     = cnt_q;
  assign busy_o    = run;
  assign done_o    = done_q;

`ifdef SMMHA_SATURATE_EN
  localparam logic [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};
  logic [DATA_W:0]     ext_sum;
  logic [2*DATA_W-1:0] prod;

  // One guard bit on add/sub; product is in range only if its top DATA_W+1 bits agree.
  always_comb begin
    ext_sum = '0;
    prod    = '0;
    alu_d   = s1_data_q;
    case (op_q)
      2'd0: begin
        ext_sum = {s1_data_q[DATA_W-1], s1_data_q} + {operand_q[DATA_W-1], operand_q};
        alu_d   = ext_sum[DATA_W-1:0];
        if (ext_sum[DATA_W] != ext_sum[DATA_W-1]) alu_d = ext_sum[DATA_W] ? SMIN : SMAX;
      end
      2'd1: begin
        ext_sum = {s1_data_q[DATA_W-1], s1_data_q} - {operand_q[DATA_W-1], operand_q};
        alu_d   = ext_sum[DATA_W-1:0];
        if (ext_sum[DATA_W] != ext_sum[DATA_W-1]) alu_d = ext_sum[DATA_W] ? SMIN : SMAX;
      end
      2'd2: begin
        prod  = {{DATA_W{s1_data_q[DATA_W-1]}}, s1_data_q} *
                {{DATA_W{operand_q[DATA_W-1]}}, operand_q};
        alu_d = prod[DATA_W-1:0];
        if (prod[2*DATA_W-1:DATA_W-1] != {(DATA_W+1){prod[2*DATA_W-1]}})
          alu_d = prod[2*DATA_W-1] ? SMIN : SMAX;
      end
      default: alu_d = s1_data_q;
    endcase
  end
`else
  always_comb begin
    alu_d = s1_data_q;
    case (op_q)
      2'd0:    alu_d = s1_data_q + operand_q;
      2'd1:    alu_d = s1_data_q - operand_q;
      2'd2:    alu_d = s1_data_q * operand_q;
      default: alu_d = s1_data_q;
    endcase
  end
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      state_q    <= IDLE;
      len_q      <= '0;
      operand_q  <= '0;
      op_q       <= '0;
      in_cnt_q   <= '0;
      cnt_q      <= '0;
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (adv) begin
        s1_valid_q <= a_hs;
        s2_valid_q <= s1_valid_q;
        if (a_hs)       s1_data_q <= a_data_i;
        if (s1_valid_q) s2_data_q <= alu_d;
      end
      if (a_hs) in_cnt_q <= in_cnt_q + CNT_W'(1);
      if (d_hs && (cnt_q < len_q)) cnt_q <= cnt_q + CNT_W'(1);
      case (state_q)
        IDLE: if (start_i) begin
          state_q   <= RUN;
          len_q     <= len_i;
          operand_q <= operand_i;
          op_q      <= operation_i;
          in_cnt_q  <= '0;
          cnt_q     <= '0;
        end
        // len=0 finishes on the first RUN cycle as if its last beat had just completed.
        RUN: if ((len_q == '0) || last_beat) begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_smmha_engine.sv
// Scoreboard bench for smmha_engine: expected words queued at stimulus time, checked at output handshakes.
module tb_smmha_engine;
  localparam int DW = 32;
  localparam int CW = 16;

  logic          clk_i = 1'b0;
  logic          rst_i = 1'b1, clear_i = 1'b0, start_i = 1'b0;
  logic [CW-1:0] len_i = '0;
  logic [DW-1:0] operand_i = '0;
  logic [1:0]    operation_i = '0;
  logic          a_valid_i = 1'b0, a_ready_o;
  logic [DW-1:0] a_data_i = '0;
  logic          d_valid_o, d_ready_i = 1'b1;
  logic [DW-1:0] d_data_o;
  logic [CW-1:0] cnt_o;
  logic          busy_o, done_o;

  int vectors = 0, errors = 0, cyc = 0;
  logic [DW-1:0] src[$];
  logic [DW-1:0] exp_q[$];
  int  done_seen = 0, out_cnt = 0, first_acc = -1, first_out = -1;
  int  stall_cyc = 0, stall_bad = 0;
  bit  rdy_seen = 0, a_hs_n = 0;

  smmha_engine #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .clear_i(clear_i), .start_i(start_i),
    .len_i(len_i), .operand_i(operand_i), .operation_i(operation_i),
    .a_valid_i(a_valid_i), .a_ready_o(a_ready_o), .a_data_i(a_data_i),
    .d_valid_o(d_valid_o), .d_ready_i(d_ready_i), .d_data_o(d_data_o),
    .cnt_o(cnt_o), .busy_o(busy_o), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: 64-bit signed arithmetic, then clamp or truncate.
  function automatic logic [DW-1:0] model(input logic [1:0] op, input logic [DW-1:0] w, input logic [DW-1:0] o);
    longint x = longint'($signed(w));
    longint y = longint'($signed(o));
    longint r;
    case (op)
      2'd0:    r = x + y;
      2'd1:    r = x - y;
      2'd2:    r = x * y;
      default: r = x;
    endcase
`ifdef SMMHA_SATURATE_EN
    if (op != 2'd3) begin
      if (r > 64'sh7FFFFFFF) r = 64'sh7FFFFFFF;
      if (r < -64'sh80000000) r = -64'sh80000000;
    end
`endif
    return r[DW-1:0];
  endfunction

  // Output monitor and scoreboard.
  always @(negedge clk_i) begin
    logic [DW-1:0] e;
    cyc++;
    a_hs_n = a_valid_i && a_ready_o && !rst_i && !clear_i;
    if (a_hs_n && first_acc < 0) first_acc = cyc;
    if (d_valid_o && first_out < 0) first_out = cyc;
    if (a_ready_o) rdy_seen = 1;
    if (d_valid_o && !d_ready_i) begin
      stall_cyc++;
      if (a_ready_o) stall_bad++;
    end
    if (done_o) done_seen++;
    if (d_valid_o && d_ready_i && !rst_i && !clear_i) begin
      vectors++;
      out_cnt++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL out_extra got=%h with empty scoreboard", d_data_o);
      end else begin
        e = exp_q.pop_front();
        if (d_data_o !== e) begin
          errors++;
          $display("FAIL out_data got=%h exp=%h", d_data_o, e);
        end
      end
    end
  end

  // Source streamer driven from the src queue.
  always @(posedge clk_i) begin
    #2;
    if (a_hs_n && src.size() > 0) void'(src.pop_front());
    a_hs_n    = 0;
    a_valid_i = (src.size() > 0);
    a_data_i  = (src.size() > 0) ? src[0] : '0;
  end

  task automatic step();
    @(posedge clk_i); #1;
  endtask

  task automatic push(input logic [DW-1:0] w, input logic [DW-1:0] e);
    src.push_back(w);
    exp_q.push_back(e);
  endtask

  task automatic start(input logic [1:0] op, input logic [DW-1:0] opnd, input logic [CW-1:0] len);
    operation_i = op; operand_i = opnd; len_i = len; start_i = 1'b1;
    step();
    start_i = 1'b0;
  endtask

  task automatic clr_stats();
    done_seen = 0; out_cnt = 0; first_acc = -1; first_out = -1;
    stall_cyc = 0; stall_bad = 0; rdy_seen = 0;
  endtask

  task automatic wait_done(input int budget, input logic [CW-1:0] exp_cnt, input string nm);
    bit ok = 0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk_i);
      if (done_o) begin
        ok = 1;
        vectors++;
        if (cnt_o !== exp_cnt || busy_o !== 1'b0) begin
          errors++;
          $display("FAIL %s_done cnt=%0d busy=%b exp cnt=%0d busy=0", nm, cnt_o, busy_o, exp_cnt);
        end
      end
      @(posedge clk_i); #1;
    end
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_timeout no done within %0d cycles", nm, budget);
    end
  endtask

  task automatic check_drained(input string nm, input int exp_done);
    repeat (4) step();
    vectors++;
    if (exp_q.size() != 0 || done_seen != exp_done) begin
      errors++;
      $display("FAIL %s_drain pending=%0d dones=%0d exp pending=0 dones=%0d", nm, exp_q.size(), done_seen, exp_done);
    end
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    repeat (2) step();
    @(negedge clk_i);
    vectors++;
    if ({a_ready_o, d_valid_o, busy_o, done_o} !== 4'b0 || d_data_o !== '0 || cnt_o !== '0) begin
      errors++;
      $display("FAIL reset_state rdy=%b dv=%b busy=%b done=%b data=%h cnt=%0d exp all 0",
               a_ready_o, d_valid_o, busy_o, done_o, d_data_o, cnt_o);
    end
    step();
    rst_i = 1'b0;
    step();
  endtask

  task automatic test_add();
    clr_stats();
    d_ready_i = 1'b1;
    push(32'd1, 32'd6); push(32'd2, 32'd7); push(32'd3, 32'd8); push(32'd4, 32'd9);
    start(2'd0, 32'd5, 16'd4);
    @(negedge clk_i);
    vectors++;
    if (a_ready_o !== 1'b1 || busy_o !== 1'b1) begin
      errors++;
      $display("FAIL add_ready_after_start rdy=%b busy=%b exp 1 1", a_ready_o, busy_o);
    end
    step();
    wait_done(20, 16'd4, "add");
    vectors++;
    if (first_out - first_acc != 2) begin
      errors++;
      $display("FAIL add_latency got=%0d exp=2", first_out - first_acc);
    end
    check_drained("add", 1);
  endtask

  task automatic test_backpressure();
    bit pat[6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    clr_stats();
    d_ready_i = 1'b1;
    push(32'd10, 32'd30); push(32'd20, 32'd60); push(32'd30, 32'd90);
    start(2'd2, 32'd3, 16'd3);
    for (int i = 0; i < 6; i++) begin
      d_ready_i = pat[i];
      step();
    end
    d_ready_i = 1'b1;
    wait_done(20, 16'd3, "bp");
    vectors++;
    if (stall_cyc == 0 || stall_bad != 0 || out_cnt != 3) begin
      errors++;
      $display("FAIL bp_stall stalls=%0d ready_in_stall=%0d outs=%0d exp stalls>0 0 3", stall_cyc, stall_bad, out_cnt);
    end
    check_drained("bp", 1);
  endtask

  task automatic test_len0();
    clr_stats();
    start(2'd0, 32'd1, 16'd0);
    @(negedge clk_i);
    vectors++;
    if (busy_o !== 1'b1 || done_o !== 1'b0) begin
      errors++;
      $display("FAIL len0_run busy=%b done=%b exp 1 0", busy_o, done_o);
    end
    step();
    @(negedge clk_i);
    vectors++;
    if (done_o !== 1'b1 || cnt_o !== '0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL len0_done done=%b cnt=%0d busy=%b exp 1 0 0", done_o, cnt_o, busy_o);
    end
    step();
    check_drained("len0", 1);
    vectors++;
    if (rdy_seen) begin
      errors++;
      $display("FAIL len0_ready got a_ready high exp never");
    end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] e_add, e_sub;
`ifdef SMMHA_SATURATE_EN
    e_add = 32'h7FFFFFFF; e_sub = 32'h80000000;
`else
    e_add = 32'h80000000; e_sub = 32'h7FFFFFFF;
`endif
    clr_stats();
    push(32'd1, e_add);
    start(2'd0, 32'h7FFFFFFF, 16'd1);
    wait_done(20, 16'd1, "ovf_add");
    push(32'h80000000, e_sub);
    start(2'd1, 32'd1, 16'd1);
    wait_done(20, 16'd1, "ovf_sub");
    push(32'h00010000, model(2'd2, 32'h00010000, 32'h00010000));
    push(32'hFFFFFFFE, model(2'd2, 32'hFFFFFFFE, 32'h00010000));
    start(2'd2, 32'h00010000, 16'd2);
    wait_done(20, 16'd2, "ovf_mul");
    check_drained("ovf", 3);
  endtask

  task automatic test_abort();
    bit hit = 0;
    clr_stats();
    d_ready_i = 1'b1;
    for (int i = 1; i <= 8; i++) push(DW'(i), model(2'd0, DW'(i), 32'd100));
    start(2'd0, 32'd100, 16'd8);
    for (int i = 0; i < 30 && !hit; i++) begin
      if (out_cnt >= 3) hit = 1;
      else step();
    end
    vectors++;
    if (!hit) begin
      errors++;
      $display("FAIL abort_wait outs=%0d exp 3 within budget", out_cnt);
    end
    clear_i = 1'b1;
    step();
    clear_i = 1'b0;
    src.delete();
    exp_q.delete();
    @(negedge clk_i);
    vectors++;
    if (d_valid_o !== 1'b0 || cnt_o !== '0 || busy_o !== 1'b0) begin
      errors++;
      $display("FAIL abort_state dv=%b cnt=%0d busy=%b exp 0 0 0", d_valid_o, cnt_o, busy_o);
    end
    step();
    clr_stats();
    push(32'd7, model(2'd3, 32'd7, 32'd55));
    push(32'hDEADBEEF, model(2'd3, 32'hDEADBEEF, 32'd55));
    start(2'd3, 32'd55, 16'd2);
    wait_done(20, 16'd2, "abort_restart");
    check_drained("abort_restart", 1);
  endtask

  task automatic test_ignored_restart();
    clr_stats();
    d_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) push(DW'(i * 3), model(2'd1, DW'(i * 3), 32'd10));
    start(2'd1, 32'd10, 16'd6);
    step();
    operand_i = 32'd1000; operation_i = 2'd0; len_i = 16'd9; start_i = 1'b1;
    step();
    start_i = 1'b0;
    wait_done(30, 16'd6, "restart");
    check_drained("restart", 1);
  endtask

  task automatic test_back_to_back();
    clr_stats();
    for (int i = 0; i < 16; i++) begin
      logic [DW-1:0] w = $urandom;
      push(w, model(2'd2, w, 32'hFFFFFFF3));
    end
    start(2'd2, 32'hFFFFFFF3, 16'd16);
    for (int i = 0; i < 40 && busy_o; i++) begin
      d_ready_i = ($urandom_range(0, 3) != 0);
      step();
    end
    d_ready_i = 1'b1;
    check_drained("b2b", 1);
  endtask

  initial begin
    test_reset();
    test_add();
    test_backpressure();
    test_len0();
    test_overflow();
    test_abort();
    test_ignored_restart();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/smmha_engine.md
# smmha_engine

Datapath engine of the smmha accelerator, sitting directly downstream of the accelerator's control FSM and between the `a` source streamer and the `d` sink streamer. It takes a start pulse plus length, scalar operand and operation code from the FSM. It consumes `len` 32-bit words from the input stream and applies `word OP operand` to each. Results are emitted on the output stream through a 2-stage stallable pipeline. A beat counter is reported back to the FSM for termination.

## Interface
- `DATA_W`, 32, stream/operand width.
- `CNT_W`, 16, width of `len_i` and `cnt_o`.
- `clk_i`  in  1  clock; single clock domain.
- `rst_i`  in  1  reset, synchronous, active-high.
- `clear_i`  in  1  synchronous soft clear; same effect as `rst_i`.
- `start_i`  in  1  start pulse; sampled only in IDLE.
- `len_i`  in  CNT_W  number of words to process; latched on start.
- `operand_i`  in  DATA_W  scalar operand; latched on start.
- `operation_i`  in  2  operation code; latched on start.
  - 0: ADD
  - 1: SUB (word − operand)
  - 2: MUL (low DATA_W bits)
  - 3: PASS (word unchanged)
- `a_valid_i`  in  1  input stream valid.
- `a_ready_o`  out  1  input stream ready.
- `a_data_i`  in  DATA_W  input word.
- `d_valid_o`  out  1  output stream valid.
- `d_ready_i`  in  1  output stream ready.
- `d_data_o`  out  DATA_W  result word.
- `cnt_o`  out  CNT_W  number of output beats handshaked since start.
- `busy_o`  out  1  high in RUN.
- `done_o`  out  1  one-cycle pulse when the last output beat completes.

## Operation
- States: IDLE, RUN.
  - IDLE→RUN on `start_i`.
  - RUN→IDLE on the cycle the `len`-th output handshake occurs; `done_o`=1 that cycle.
  - Special case `len_i`=0: go RUN→IDLE one cycle after start with `done_o`=1; no beats are accepted.
- On start: latch len, operand and op; zero `cnt_o` and the internal input counter `in_cnt`.
- Pipeline: stage S1 registers the input word; stage S2 registers the computed result.
  - Advance enable is `adv = !s2_valid | d_ready_i`.
  - When `adv` is low, both stages hold.
  - Nothing is dropped or duplicated under backpressure.
- `a_ready_o = RUN & (in_cnt < len) & adv`. An input handshake increments `in_cnt`.
- `cnt_o` increments on each `d_valid_o & d_ready_i`. It saturates at len and holds in IDLE until the next start.
- Arithmetic is computed in S1→S2 on DATA_W bits. Default behaviour wraps modulo 2^DATA_W; MUL keeps the low DATA_W bits of the signed product.
- `start_i` while in RUN is ignored; latched parameters are unchanged.
- Changes on `operand_i`, `operation_i` or `len_i` during RUN have no effect.
- `rst_i` or `clear_i` mid-run returns the block to IDLE immediately.
  - All valids, counters and latched parameters are zeroed.
  - In-flight data is discarded.
  - `clear_i` has priority over `start_i` in the same cycle.

## Timing
- Reset values: `a_ready_o`=0, `d_valid_o`=0, `d_data_o`=0, `cnt_o`=0, `busy_o`=0, `done_o`=0.
- Latency: a word accepted at cycle N appears on `d_data_o` with `d_valid_o`=1 at cycle N+2 with no backpressure.
- Throughput: 1 word/cycle.
- `a_ready_o` rises the cycle after `start_i` is sampled.
- `d_valid_o` must not depend combinationally on `d_ready_i`.
- `a_ready_o` may depend combinationally on `d_ready_i` through `adv`.
- `done_o` is registered-state-driven and high for exactly one cycle. `cnt_o` equals len in that same cycle.

## Configuration
- `SMMHA_SATURATE_EN` defined: ADD, SUB and MUL treat operands as signed two's complement and clamp results to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. PASS is unaffected.
- Undefined: all operations wrap modulo 2^DATA_W.

## Test plan
- ADD stream: len=4, operand=5, op=0, inputs 1,2,3,4 with ready always high.
  - Outputs are 6,7,8,9.
  - First output appears 2 cycles after the first accept.
  - `done_o` pulses with `cnt_o`=4.
- Backpressure: MUL, operand=3, inputs 10,20,30; toggle `d_ready_i` 1-0-0-1-0-1.
  - Outputs are exactly 30,60,90 in order with no loss or duplication.
  - `a_ready_o`=0 while the pipeline is full and stalled.
- Boundary: len=0 start.
  - `a_ready_o` never rises.
  - `done_o` pulses once, 1 cycle after start; `cnt_o`=0.
- Overflow: ADD, operand=0x7FFFFFFF, input 1.
  - Output is 0x80000000 without `SMMHA_SATURATE_EN`.
  - Output is 0x7FFFFFFF with it.
  - SUB 0x80000000−1 clamps to 0x80000000 with the macro.
- Abort: len=8; assert `clear_i` after 3 outputs while data is in flight.
  - Next cycle: `d_valid_o`=0, `cnt_o`=0, `busy_o`=0.
  - A subsequent start with len=2 completes normally.
- Ignored restart: `start_i` pulsed in RUN with a different operand.
  - Results continue using the original operand.
  - Only one `done_o` is produced.
